// File: rtl/cpu_step_ctrl_if.sv
// Handshake bundle between the board I/O and the step controller.
// The master side drives the switches/key; the slave side is the controller.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             key_n;
  logic             mode;
  logic [1:0]       rate;
  logic             step_en;
  logic [CNT_W-1:0] step_count;
  logic             running;

  modport master (
    output key_n, mode, rate,
    input  step_en, step_count, running
  );

  modport slave (
    input  key_n, mode, rate,
    output step_en, step_count, running
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Execution-pacing controller: produces a one-cycle step_en for the core,
// either from a debounced key press (manual) or a clock divider (auto).
module cpu_step_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 16
) (
  input logic           clk,
  input logic           reset,
  cpu_step_ctrl_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_HZ) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int P1    = (CLK_HZ >= 10)  ? CLK_HZ / 10  : 1;
  localparam int P2    = (CLK_HZ >= 100) ? CLK_HZ / 100 : 1;

  localparam logic [DIV_W-1:0] LAST0   = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] LAST1   = DIV_W'(P1 - 1);
  localparam logic [DIV_W-1:0] LAST2   = DIV_W'(P2 - 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       key_s;
  logic [1:0]       mode_s;
  logic [1:0]       rate_s1;
  logic [1:0]       rate_s2;
  logic             key_sync;
  logic             running;

  logic             stable;
  logic             stable_d;
  logic [DB_W-1:0]  db_cnt;

  logic [1:0]       rate_q;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_last;
  logic             rate_chg;
  logic             div_hit;
  logic             press;
  logic             step_next;

  logic             step_en;
  logic [CNT_W-1:0] count;

  assign key_sync = key_s[1];
  assign running  = mode_s[1];

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s   <= 2'b11;
      mode_s  <= 2'b00;
      rate_s1 <= 2'b00;
      rate_s2 <= 2'b00;
    end else begin
      key_s   <= {key_s[0], bus.key_n};
      mode_s  <= {mode_s[0], bus.mode};
      rate_s1 <= bus.rate;
      rate_s2 <= rate_s1;
    end
  end

  // Debouncer: accept a new key level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= 1'b1;
      stable_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      stable_d <= stable;
      if (key_sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= key_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Period select, divider terminal count and step source selection.
  always_comb begin
    div_last = LAST0;
    case (rate_q)
      2'b00:   div_last = LAST0;
      2'b01:   div_last = LAST1;
      2'b10:   div_last = LAST2;
      default: div_last = '0;
    endcase
    rate_chg  = (rate_s2 != rate_q);
    div_hit   = (div == div_last);
    press     = stable_d & ~stable;
    // A rate change restarts the period, so the coinciding terminal count is dropped.
    step_next = running ? (div_hit & ~rate_chg) : press;
  end

  // Auto-mode divider; the registered rate copy tracks the synced switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q <= 2'b00;
      div    <= '0;
    end else begin
      if (rate_chg) rate_q <= rate_s2;
      if (!running || rate_chg || div_hit) div <= '0;
      else div <= div + 1'b1;
    end
  end

  // Registered step enable and wrapping step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_en <= 1'b0;
      count   <= '0;
    end else begin
      step_en <= step_next;
      if (step_en) count <= count + 1'b1;
    end
  end

  assign bus.step_en    = step_en;
  assign bus.step_count = count;
  assign bus.running    = running;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, CLK_HZ=100, CNT_W=4.
module tb_cpu_step_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_step_ctrl_if #(.CNT_W(4)) bus ();

  cpu_step_ctrl #(
    .CLK_HZ(100),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       key_n;
    logic       mode;
    logic [1:0] rate;
    logic       rst;
    logic       es;
    logic       er;
  } vec_t;

  vec_t       vecs[16];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic       prev_step = 1'b0;
  int         pulses;

  // Advance one edge and update the step-count model from the previous expectation.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) exp_cnt = 4'd0;
    else if (prev_step) exp_cnt = exp_cnt + 4'd1;
    prev_step = 1'b0;
  endtask

  task automatic check(input string name, input logic es, input logic er);
    tests++;
    if (bus.step_en !== es) begin
      fails++;
      $display("FAIL %s step_en got %b want %b at %0t", name, bus.step_en, es, $time);
    end
    tests++;
    if (bus.running !== er) begin
      fails++;
      $display("FAIL %s running got %b want %b at %0t", name, bus.running, er, $time);
    end
    tests++;
    if (bus.step_count !== exp_cnt) begin
      fails++;
      $display("FAIL %s step_count got %0d want %0d at %0t", name, bus.step_count, exp_cnt, $time);
    end
    prev_step = es;
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.key_n = 1'b1;
    bus.mode = 1'b0;
    bus.rate = 2'b00;
    tick();
    tick();
    check("reset_state", 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic preset_rate(input logic [1:0] r);
    bus.rate = r;
    repeat (4) begin
      tick();
      check("preset", 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.key_n = 1'b1;
    bus.mode = 1'b0;
    bus.rate = 2'b00;
    reset = 1'b1;

    // Clean press then release: pulse after edge 6 only.
    for (int i = 0; i < 16; i++) begin
      vecs[i].key_n = (i < 8) ? 1'b0 : 1'b1;
      vecs[i].mode  = 1'b0;
      vecs[i].rate  = 2'b00;
      vecs[i].rst   = 1'b0;
      vecs[i].es    = (i == 6);
      vecs[i].er    = 1'b0;
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.key_n = vecs[i].key_n;
      bus.mode  = vecs[i].mode;
      bus.rate  = vecs[i].rate;
      reset     = vecs[i].rst;
      tick();
      check($sformatf("clean[%0d]", i), vecs[i].es, vecs[i].er);
    end
    expect_int("clean_count", int'(bus.step_count), 1);

    // Bouncy press: 2-cycle glitches, then held low from edge 20.
    do_reset();
    for (int i = 0; i < 44; i++) begin
      if (i < 20) bus.key_n = ((i % 4) >= 2);
      else if (i < 32) bus.key_n = 1'b0;
      else bus.key_n = 1'b1;
      tick();
      check($sformatf("bouncy[%0d]", i), (i == 26), 1'b0);
    end
    expect_int("bouncy_count", int'(bus.step_count), 1);

    // Auto at P=10, key press while running, then auto->manual with key held.
    do_reset();
    preset_rate(2'b01);
    pulses = 0;
    for (int i = 0; i < 231; i++) begin
      bus.mode  = (i <= 210);
      bus.key_n = !(i >= 100);
      tick();
      if (i <= 210 && bus.step_en === 1'b1) pulses++;
      check($sformatf("auto10[%0d]", i),
            (i >= 11 && i <= 211 && ((i - 11) % 10) == 0),
            (i >= 1 && i <= 211));
    end
    expect_int("auto10_pulses", pulses, 20);

    // Full speed and counter wrap.
    do_reset();
    preset_rate(2'b11);
    for (int i = 0; i < 25; i++) begin
      bus.mode = 1'b1;
      tick();
      check($sformatf("full[%0d]", i), (i >= 2), (i >= 1));
      if (i == 17) expect_int("full_count_15", int'(bus.step_count), 15);
      if (i == 18) expect_int("full_wrap_0", int'(bus.step_count), 0);
    end

    // Rate 00 -> 10 mid-count: change lands at edge 52, steps from edge 53.
    do_reset();
    for (int i = 0; i < 71; i++) begin
      bus.mode = 1'b1;
      if (i == 50) bus.rate = 2'b10;
      tick();
      check($sformatf("ratechg[%0d]", i), (i >= 53), (i >= 1));
    end

    // Rate change on the terminal-count edge suppresses that step.
    do_reset();
    preset_rate(2'b01);
    for (int i = 0; i < 31; i++) begin
      bus.mode = 1'b1;
      if (i == 19) bus.rate = 2'b10;
      tick();
      check($sformatf("suppress[%0d]", i), (i == 11 || i >= 22), (i >= 1));
    end

    // Reset mid-run at step_count 7 in auto mode (P=100).
    do_reset();
    for (int i = 0; i < 831; i++) begin
      bus.mode = 1'b1;
      reset = (i == 710);
      tick();
      if (i == 709) expect_int("midrst_count_7", int'(bus.step_count), 7);
      check($sformatf("midrst[%0d]", i),
            ((i < 710 && i >= 101 && ((i - 101) % 100) == 0) || i == 812),
            ((i >= 1 && i < 710) || i >= 712));
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
